// File: rtl/cgra_obi_arb_pkg.sv
// Shared OBI widths and arbiter lock-state encoding for the CGRA master arbiter.
package cgra_obi_arb_pkg;

  localparam int unsigned ObiAddrW = 32;
  localparam int unsigned ObiDataW = 32;
  localparam int unsigned ObiBeW   = 4;

  typedef enum logic {
    LOCK_OPEN,
    LOCK_HELD
  } lock_state_e;

endpackage

// File: rtl/cgra_obi_id_fifo.sv
// Synchronous FIFO of requester indices for outstanding OBI transactions.
// Push and pop may occur in the same cycle; pointers wrap modulo Depth.
module cgra_obi_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (PtrW+1)'(Depth));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cgra_obi_master_arbiter.sv
// Round-robin merge of NumReq CGRA OBI master channels onto one OBI master port,
// with an ID FIFO routing each response back to the channel that issued it.
module cgra_obi_master_arbiter
  import cgra_obi_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned MaxOutstd = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq*ObiBeW-1:0]     be_i,
  input  logic [NumReq*ObiAddrW-1:0]   addr_i,
  input  logic [NumReq*ObiDataW-1:0]   wdata_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            rvalid_o,
  output logic [NumReq*ObiDataW-1:0]   rdata_o,
  output logic                         out_req_o,
  output logic                         out_we_o,
  output logic [ObiBeW-1:0]            out_be_o,
  output logic [ObiAddrW-1:0]          out_addr_o,
  output logic [ObiDataW-1:0]          out_wdata_o,
  input  logic                         out_gnt_i,
  input  logic                         out_rvalid_i,
  input  logic [ObiDataW-1:0]          out_rdata_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstd) + 1;

  lock_state_e       lock_state;
  logic [IdxW-1:0]   lock_idx;
  logic [IdxW-1:0]   rr_ptr;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   cand;
  logic              found;
  logic [IdxW-1:0]   sel_idx;
  logic              out_req;
  logic              handshake;
  logic              resp_bypass;
  logic              resp_valid;
  logic [IdxW-1:0]   resp_idx;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IdxW-1:0]   fifo_head;
  logic [CntW-1:0]   fifo_count;
  logic              err_q;

  // First asserted request at or after the rr pointer, wrapping.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(rr_ptr) + i) % NumReq);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel_idx   = (lock_state == LOCK_HELD) ? lock_idx : winner;
  assign out_req   = ~rst_i & ((lock_state == LOCK_HELD) | (|req_i)) & ~fifo_full;
  assign handshake = out_req & out_gnt_i;

  // A response arriving while the FIFO is empty but a grant happens in the same
  // cycle belongs to that grant; it bypasses the FIFO instead of raising err_o.
  assign resp_bypass = out_rvalid_i & fifo_empty & handshake;
  assign resp_valid  = ~rst_i & out_rvalid_i & (~fifo_empty | handshake);
  assign resp_idx    = fifo_empty ? sel_idx : fifo_head;
  assign fifo_push   = handshake & ~resp_bypass;
  assign fifo_pop    = ~rst_i & out_rvalid_i & ~fifo_empty;

  cgra_obi_id_fifo #(
    .Depth (MaxOutstd),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (sel_idx),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    out_we_o    = 1'b0;
    out_be_o    = '0;
    out_addr_o  = '0;
    out_wdata_o = '0;
    if (out_req) begin
      out_we_o    = we_i[sel_idx];
      out_be_o    = be_i[sel_idx*ObiBeW +: ObiBeW];
      out_addr_o  = addr_i[sel_idx*ObiAddrW +: ObiAddrW];
      out_wdata_o = wdata_i[sel_idx*ObiDataW +: ObiDataW];
    end
  end

  assign out_req_o = out_req;
  assign gnt_o     = handshake  ? (NumReq'(1) << sel_idx)  : '0;
  assign rvalid_o  = resp_valid ? (NumReq'(1) << resp_idx) : '0;
  assign rdata_o   = rst_i ? '0 : {NumReq{out_rdata_i}};
  assign busy_o    = (fifo_count != '0);
  assign err_o     = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_state <= LOCK_OPEN;
      lock_idx   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr     <= (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + 1'b1;
        lock_state <= LOCK_OPEN;
      end else if (out_req) begin
        lock_state <= LOCK_HELD;
        lock_idx   <= sel_idx;
      end
      if (out_rvalid_i & fifo_empty & ~handshake) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cgra_obi_master_arbiter.sv
// Randomized scoreboard bench for cgra_obi_master_arbiter with directed corner sequences.
module tb_cgra_obi_master_arbiter;

  localparam int N    = 4;
  localparam int MAXO = 4;

  typedef struct { int idx; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { int idx; logic [31:0] data; } rsp_t;
  typedef struct { logic oreq; logic [31:0] addr; logic busy; logic err; } cyc_t;
  typedef enum { RV_OFF, RV_ON, RV_AUTO, RV_RAND } rv_mode_e;

  logic         clk;
  logic         rst;
  logic [3:0]   req_v;
  logic [3:0]   we_v;
  logic [15:0]  be_v;
  logic [127:0] addr_v;
  logic [127:0] wdata_v;
  logic         gnt_in;
  logic         rv_in;
  logic [31:0]  rdata_in;

  logic [3:0]   gnt;
  logic [3:0]   rvalid;
  logic [127:0] rdata;
  logic         out_req;
  logic         out_we;
  logic [3:0]   out_be;
  logic [31:0]  out_addr;
  logic [31:0]  out_wdata;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  txn_t gq[$];
  rsp_t rq[$];
  cyc_t cq[$];
  int   mq[$];
  bit   mlock;
  int   mlidx;
  int   mrr;
  bit   merr;

  cgra_obi_master_arbiter #(.NumReq(4), .MaxOutstd(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req_v),
    .we_i         (we_v),
    .be_i         (be_v),
    .addr_i       (addr_v),
    .wdata_i      (wdata_v),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .out_req_o    (out_req),
    .out_we_o     (out_we),
    .out_be_o     (out_be),
    .out_addr_o   (out_addr),
    .out_wdata_o  (out_wdata),
    .out_gnt_i    (gnt_in),
    .out_rvalid_i (rv_in),
    .out_rdata_i  (rdata_in),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  // Reference model: evaluated once per cycle, after inputs settle.
  always @(posedge clk) begin
    cyc_t c;
    txn_t t;
    rsp_t r;
    bit   oreq, hs, bypass;
    int   owner;
    #2;
    c.busy = (mq.size() != 0);
    c.err  = merr;
    if (rst) begin
      c.oreq = 1'b0;
      c.addr = '0;
      mq.delete();
      mlock = 0;
      mrr   = 0;
      merr  = 0;
    end else begin
      oreq   = (mlock || req_v != 0) && (mq.size() < MAXO);
      owner  = mlock ? mlidx : pick(req_v, mrr);
      hs     = oreq && gnt_in;
      c.oreq = oreq;
      c.addr = oreq ? addr_v[owner*32 +: 32] : 32'h0;
      bypass = 0;
      if (rv_in) begin
        if (mq.size() != 0) begin
          r.idx = mq.pop_front(); r.data = rdata_in; rq.push_back(r);
        end else if (hs) begin
          bypass = 1; r.idx = owner; r.data = rdata_in; rq.push_back(r);
        end else begin
          merr = 1;
        end
      end
      if (hs) begin
        t.idx = owner; t.we = we_v[owner]; t.be = be_v[owner*4 +: 4];
        t.addr = addr_v[owner*32 +: 32]; t.wdata = wdata_v[owner*32 +: 32];
        gq.push_back(t);
        if (!bypass) mq.push_back(owner);
        mrr   = (owner + 1) % N;
        mlock = 0;
      end else if (oreq) begin
        mlock = 1;
        mlidx = owner;
      end
    end
    cq.push_back(c);
  end

  // Monitor: per-cycle status plus transaction-level grant/response checks.
  always @(negedge clk) begin
    cyc_t mc;
    txn_t mt;
    rsp_t mr;
    if (cq.size() != 0) begin
      mc = cq.pop_front();
      check("out_req", out_req, mc.oreq);
      check("out_addr", out_addr, mc.addr);
      check("busy", busy, mc.busy);
      check("err", err, mc.err);
    end
    if (gnt != 0) begin
      if (gq.size() == 0) check("gnt_unexpected", gnt, 0);
      else begin
        mt = gq.pop_front();
        check("gnt_lane", gnt, 4'b0001 << mt.idx);
        check("out_we", out_we, mt.we);
        check("out_be", out_be, mt.be);
        check("out_wdata", out_wdata, mt.wdata);
      end
    end
    if (rvalid != 0) begin
      if (rq.size() == 0) check("rvalid_unexpected", rvalid, 0);
      else begin
        mr = rq.pop_front();
        check("rvalid_lane", rvalid, 4'b0001 << mr.idx);
        check("rdata", rdata, {4{mr.data}});
      end
    end
  end

  task automatic drive(input logic rs, input logic [3:0] r, input logic g, input rv_mode_e rvm, input bit newpay);
    @(posedge clk);
    #1;
    rst      = rs;
    req_v    = r;
    gnt_in   = g;
    rdata_in = $urandom;
    if (newpay) begin
      we_v    = 4'($urandom);
      be_v    = 16'($urandom);
      addr_v  = {$urandom, $urandom, $urandom, $urandom};
      wdata_v = {$urandom, $urandom, $urandom, $urandom};
    end
    case (rvm)
      RV_ON:   rv_in = 1'b1;
      RV_AUTO: rv_in = !rs && mq.size() != 0;
      RV_RAND: rv_in = !rs && mq.size() != 0 && $urandom_range(0, 1) == 1;
      default: rv_in = 1'b0;
    endcase
  endtask

  task automatic drain();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (mq.size() == 0 && !mlock) break;
      drive(1'b0, 4'b0000, 1'b1, RV_AUTO, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a1;
    rst = 1'b1; req_v = '0; we_v = '0; be_v = '0; addr_v = '0; wdata_v = '0;
    gnt_in = 1'b0; rv_in = 1'b0; rdata_in = '0;
    mlock = 0; mlidx = 0; mrr = 0; merr = 0;
    drive(1'b1, 4'b0000, 1'b0, RV_OFF, 1'b1);
    @(negedge clk);
    check("reset_out_req", out_req, 1'b0);
    check("reset_gnt", gnt, 4'b0000);

    // Single read on ch2.
    drive(1'b0, 4'b0100, 1'b1, RV_OFF, 1'b1);
    addr_v[95:64] = 32'h100; we_v[2] = 1'b0;
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0100);
    check("t1_addr", out_addr, 32'h100);
    drive(1'b0, 4'b0000, 1'b0, RV_ON, 1'b1);
    rdata_in = 32'hCAFE;
    @(negedge clk);
    check("t1_rvalid", rvalid, 4'b0100);
    check("t1_rdata", rdata[95:64], 32'hCAFE);

    // All requesting, rotating grants.
    drive(1'b1, 4'b0000, 1'b0, RV_OFF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b1111, 1'b1, RV_AUTO, 1'b1);
      @(negedge clk);
      check("t2_order", gnt, 4'b0001 << (k % 4));
    end
    drain();

    // Lock holds ch1 while ch0 rises.
    drive(1'b1, 4'b0000, 1'b0, RV_OFF, 1'b1);
    drive(1'b0, 4'b0010, 1'b0, RV_OFF, 1'b1);
    a1 = addr_v[63:32];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_locked_addr", out_addr, a1);
      drive(1'b0, 4'b0011, (k == 2), RV_OFF, 1'b0);
    end
    @(negedge clk);
    check("t3_gnt_ch1", gnt, 4'b0010);
    drive(1'b0, 4'b0001, 1'b1, RV_OFF, 1'b1);
    @(negedge clk);
    check("t3_gnt_ch0", gnt, 4'b0001);
    drain();

    // Fill the ID FIFO.
    for (int k = 0; k < 4; k++) drive(1'b0, 4'b1111, 1'b1, RV_OFF, 1'b1);
    drive(1'b0, 4'b1111, 1'b1, RV_OFF, 1'b1);
    @(negedge clk);
    check("t4_full_req", out_req, 1'b0);
    check("t4_full_busy", busy, 1'b1);
    drive(1'b0, 4'b1111, 1'b1, RV_ON, 1'b1);
    @(negedge clk);
    check("t4_pop_same_cycle", out_req, 1'b0);
    drive(1'b0, 4'b1111, 1'b0, RV_OFF, 1'b1);
    @(negedge clk);
    check("t4_unblocked", out_req, 1'b1);
    drain();

    // Response with nothing outstanding.
    drive(1'b0, 4'b0000, 1'b0, RV_ON, 1'b1);
    @(negedge clk);
    check("t5_no_rvalid", rvalid, 4'b0000);
    drive(1'b0, 4'b0000, 1'b0, RV_OFF, 1'b1);
    @(negedge clk);
    check("t5_err_set", err, 1'b1);
    drive(1'b1, 4'b0000, 1'b0, RV_OFF, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, RV_OFF, 1'b1);
    @(negedge clk);
    check("t5_err_cleared", err, 1'b0);
    check("t5_busy_cleared", busy, 1'b0);

    // Reset with two outstanding.
    drive(1'b0, 4'b1111, 1'b1, RV_OFF, 1'b1);
    drive(1'b0, 4'b1111, 1'b1, RV_OFF, 1'b1);
    @(negedge clk);
    check("t6_busy_before", busy, 1'b1);
    drive(1'b1, 4'b1111, 1'b1, RV_OFF, 1'b1);
    drive(1'b0, 4'b1111, 1'b1, RV_OFF, 1'b1);
    @(negedge clk);
    check("t6_busy_after", busy, 1'b0);
    check("t6_ch0_wins", gnt, 4'b0001);
    drain();

    // Random traffic, occasional resets.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 299) == 0), 4'($urandom), ($urandom_range(0, 2) != 0), RV_RAND, 1'b1);
    end
    drain();
    drive(1'b0, 4'b0000, 1'b0, RV_OFF, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, RV_OFF, 1'b1);
    @(negedge clk);
    #1;
    check("grants_left", gq.size(), 0);
    check("responses_left", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
